// File: rtl/resp_misr.sv
// Multiple-input signature register compacting VEC_LENGTH DUT response samples per run.
// Optional X-masking of response bits is enabled by defining RESP_MISR_XMASK_EN (adds x_mask input).
module resp_misr #(
  parameter int                    RESP_WIDTH = 8,
  parameter int                    VEC_LENGTH = 1024,
  parameter logic [RESP_WIDTH-1:0] POLY       = RESP_WIDTH'(8'h1D),
  parameter logic [RESP_WIDTH-1:0] SEED       = '0,
  localparam int                   CNT_W      = $clog2(VEC_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  resp_valid,
  input  logic [RESP_WIDTH-1:0] resp,
`ifdef RESP_MISR_XMASK_EN
  input  logic [RESP_WIDTH-1:0] x_mask,
`endif
  input  logic [RESP_WIDTH-1:0] expected_sig,
  output logic                  busy,
  output logic                  done,
  output logic                  match,
  output logic [RESP_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]      sample_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [RESP_WIDTH-1:0]   resp_eff;
  logic [RESP_WIDTH-1:0]   sig_compacted;
  logic                    compact;
  logic                    last_sample;

`ifdef RESP_MISR_XMASK_EN
  assign resp_eff = resp & ~x_mask;
`else
  assign resp_eff = resp;
`endif

  assign compact       = (state == RUN) && resp_valid;
  assign last_sample   = (sample_cnt == CNT_W'(VEC_LENGTH - 1));
  assign sig_compacted = {signature[RESP_WIDTH-2:0], 1'b0}
                       ^ (signature[RESP_WIDTH-1] ? POLY : '0)
                       ^ resp_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (resp_valid && last_sample) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Signature and count reload on any accepted start; RUN ignores start entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature  <= SEED;
      sample_cnt <= '0;
    end else if ((state != RUN) && start) begin
      signature  <= SEED;
      sample_cnt <= '0;
    end else if (compact) begin
      signature  <= sig_compacted;
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign match = done && (signature == expected_sig);

endmodule

// File: tb/tb_resp_misr.sv
// Directed scoreboard bench for resp_misr (W=8, POLY=8'h1D, SEED=0, VEC_LENGTH=2).
// Defining RESP_MISR_XMASK_EN also exercises the x_mask input.
module tb_resp_misr;

  localparam int W     = 8;
  localparam int VLEN  = 2;
  localparam int CNT_W = $clog2(VLEN + 1);

  typedef struct {
    logic [W-1:0]     sig;
    logic [CNT_W-1:0] cnt;
  } run_result_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             resp_valid = 1'b0;
  logic [W-1:0]     resp = '0;
  logic [W-1:0]     expected_sig = '0;
`ifdef RESP_MISR_XMASK_EN
  logic [W-1:0]     x_mask = '0;
`endif
  logic             busy;
  logic             done;
  logic             match;
  logic [W-1:0]     signature;
  logic [CNT_W-1:0] sample_cnt;

  int total = 0;
  int bad = 0;
  int runs_seen = 0;
  int runs_issued = 0;
  run_result_t sb_q[$];
  logic done_q = 1'b0;

  resp_misr #(
    .RESP_WIDTH(W),
    .VEC_LENGTH(VLEN),
    .POLY(8'h1D),
    .SEED(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .resp_valid(resp_valid),
    .resp(resp),
`ifdef RESP_MISR_XMASK_EN
    .x_mask(x_mask),
`endif
    .expected_sig(expected_sig),
    .busy(busy),
    .done(done),
    .match(match),
    .signature(signature),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs from a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic st, input logic v, input logic [W-1:0] r);
    start      = st;
    resp_valid = v;
    resp       = r;
    @(negedge clk);
    start      = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic expectRun(input logic [W-1:0] sig, input logic [CNT_W-1:0] cnt);
    run_result_t e;
    e.sig = sig;
    e.cnt = cnt;
    sb_q.push_back(e);
    runs_issued++;
  endtask

  // Monitor: each entry into DONE consumes one scoreboard entry.
  always @(negedge clk) begin
    if (done && !done_q) begin
      runs_seen++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'(0));
      end else begin
        run_result_t e;
        e = sb_q.pop_front();
        checkOutput("final_signature", 64'(signature), 64'(e.sig));
        checkOutput("final_sample_cnt", 64'(sample_cnt), 64'(e.cnt));
      end
    end
    done_q = done;
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_match", 64'(match), 64'(0));
    checkOutput("reset_signature", 64'(signature), 64'h00);
    checkOutput("reset_sample_cnt", 64'(sample_cnt), 64'(0));

    // Basic run: 01 then 00 -> 01, 02
    expectRun(8'h02, 2'd2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("run1_busy", 64'(busy), 64'(1));
    checkOutput("run1_seed", 64'(signature), 64'h00);
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("run1_sig_a", 64'(signature), 64'h01);
    checkOutput("run1_cnt_a", 64'(sample_cnt), 64'(1));
    checkOutput("run1_done_early", 64'(done), 64'(0));
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("run1_done", 64'(done), 64'(1));
    checkOutput("run1_busy_end", 64'(busy), 64'(0));
    expected_sig = 8'h02;
    #1 checkOutput("run1_match_hit", 64'(match), 64'(1));
    expected_sig = 8'h03;
    #1 checkOutput("run1_match_miss", 64'(match), 64'(0));
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("done_ignores_valid_sig", 64'(signature), 64'h02);
    checkOutput("done_ignores_valid_cnt", 64'(sample_cnt), 64'(2));

    // Restart from DONE, then feedback: 80 then 00 -> 80, 1D
    expected_sig = 8'h00;
    expectRun(8'h1D, 2'd2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("restart_busy", 64'(busy), 64'(1));
    checkOutput("restart_done", 64'(done), 64'(0));
    checkOutput("restart_match", 64'(match), 64'(0));
    checkOutput("restart_sig", 64'(signature), 64'h00);
    checkOutput("restart_cnt", 64'(sample_cnt), 64'(0));
    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("fb_preload", 64'(signature), 64'h80);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("fb_result", 64'(signature), 64'h1D);

    // Gaps and start during RUN: 01, gap, gap+start, 03 -> 01, 01
    expectRun(8'h01, 2'd2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    checkOutput("gap_sig", 64'(signature), 64'h01);
    checkOutput("gap_cnt", 64'(sample_cnt), 64'(1));
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("start_in_run_cnt", 64'(sample_cnt), 64'(1));
    checkOutput("start_in_run_sig", 64'(signature), 64'h01);
    checkOutput("start_in_run_busy", 64'(busy), 64'(1));
    applyStimulus(1'b0, 1'b1, 8'h03);
    checkOutput("gap_done", 64'(done), 64'(1));

    // Reset mid-run after one sample
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("midrun_sig", 64'(signature), 64'h55);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'hAA);
    rst = 1'b0;
    checkOutput("midrst_sig", 64'(signature), 64'h00);
    checkOutput("midrst_cnt", 64'(sample_cnt), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    // Normal run after reset: 12 then 34 -> 12, 10
    expectRun(8'h10, 2'd2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h12);
    applyStimulus(1'b0, 1'b1, 8'h34);
    checkOutput("postrst_done", 64'(done), 64'(1));

`ifdef RESP_MISR_XMASK_EN
    expectRun(8'h00, 2'd2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    x_mask = 8'hFF;
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkOutput("xmask_sig", 64'(signature), 64'h00);
    x_mask = 8'h00;
    applyStimulus(1'b0, 1'b1, 8'h00);
`endif

    repeat (3) @(negedge clk);
    checkOutput("runs_completed", 64'(runs_seen), 64'(runs_issued));
    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, wanted finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/resp_misr.md
RESP_MISR -- requirements
Module: resp_misr

Interface
REQ-001 Parameter RESP_WIDTH, default 8, sets the DUT response vector width in bits (legal range 2..64).
REQ-002 Parameter VEC_LENGTH, default 1024, sets the number of response samples compacted per run (legal range 1..2^20).
REQ-003 Parameter POLY, default 8'h1D (width RESP_WIDTH), sets the MISR feedback polynomial taps.
REQ-004 Parameter SEED, default 0 (width RESP_WIDTH), sets the signature value loaded at run start.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a compaction run.
REQ-008 resp_valid  input  1  resp holds a valid DUT response sample this cycle.
REQ-009 resp  input  RESP_WIDTH  DUT response vector, sampled once per applied test vector.
REQ-010 expected_sig  input  RESP_WIDTH  golden signature; must be stable while done=1.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.
REQ-013 match  output  1  in DONE, signature==expected_sig; 0 in all other states.
REQ-014 signature  output  RESP_WIDTH  current MISR contents.
REQ-015 sample_cnt  output  clog2(VEC_LENGTH+1)  number of samples compacted in the current or last run.

Function
REQ-016 The FSM shall have exactly three states, IDLE, RUN and DONE, with IDLE entered on reset.
REQ-017 In IDLE or DONE, start=1 shall move to RUN on the next edge, load signature<=SEED and clear sample_cnt to 0.
REQ-018 In RUN, start shall be ignored.
REQ-019 In RUN with resp_valid=1, the block shall update signature <= {signature[W-2:0],1'b0} ^ (signature[W-1] ? POLY : 0) ^ resp_eff, and increment sample_cnt by 1.
REQ-020 resp_eff shall be resp when RESP_MISR_XMASK_EN is not defined (see REQ-028).
REQ-021 In RUN with resp_valid=0, signature and sample_cnt shall hold.
REQ-022 On the edge that compacts sample number VEC_LENGTH, the FSM shall move to DONE, giving done=1 one cycle after the final valid sample.
REQ-023 In IDLE and DONE, resp_valid shall be ignored, and signature and sample_cnt shall hold.
REQ-024 match shall be combinational from signature and expected_sig, gated by the DONE state.
REQ-025 When VEC_LENGTH=1, the first valid sample in RUN shall end the run.
REQ-026 sample_cnt shall never exceed VEC_LENGTH and shall not wrap.

Reset
REQ-027 When rst=1 at a rising edge, the block shall enter IDLE with signature=SEED, sample_cnt=0, busy=0, done=0 and match=0, overriding start and resp_valid, including mid-run.

Configuration
REQ-028 Macro RESP_MISR_XMASK_EN defined: an extra input x_mask [RESP_WIDTH] is added, and resp_eff = resp & ~x_mask, so that masked (unknown) bits do not corrupt the signature.
REQ-029 Macro RESP_MISR_XMASK_EN undefined: the x_mask port does not exist, and resp_eff = resp.

Verification
REQ-030 Use W=8, POLY=8'h1D, SEED=0, VEC_LENGTH=2; start, then valid resp=8'h01 and 8'h00 -> signature 8'h01 then 8'h02; done=1 on the following cycle with sample_cnt=2; expected_sig=8'h02 -> match=1; expected_sig=8'h03 -> match=0.
REQ-031 Feedback check: preload signature to 8'h80 by compacting resp=8'h80 from SEED 0, then compact resp=8'h00 -> signature 8'h1D.
REQ-032 Gaps and ignore rules: resp_valid toggling 1,0,0,1 during RUN -> only two compactions occur; a start pulse during RUN -> no restart and sample_cnt unaffected.
REQ-033 Reset mid-run after 1 of 2 samples -> next cycle IDLE, signature=8'h00, sample_cnt=0, busy=0, done=0; a subsequent start completes a normal run.
REQ-034 Restart from DONE with start -> RUN, signature=SEED, sample_cnt=0, done=0 and match=0 on the next cycle.
REQ-035 With RESP_MISR_XMASK_EN defined, x_mask=8'hFF and resp=8'hA5 -> signature unchanged apart from the shift/feedback term (8'h00 from SEED 0).
